vga_rect_renderer: RTL

//  Parametrised VGA timing generator plus NUM_RECTS-channel rectangle compositor.

---
 rtl/vga_rect_renderer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/vga_rect_renderer.sv
// VGA timing generator with a NUM_RECTS-channel, fixed-priority rectangle compositor.
// Optional macro VGA_BORDER_EN forces a white one-pixel frame around the active area.
module vga_rect_renderer #(
    parameter int CW        = 10,
    parameter int NUM_RECTS = 4,
    parameter int CLK_DIV   = 2,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic                    board_clk,
    input  logic                    Reset,
    input  logic [NUM_RECTS-1:0]    rect_en,
    input  logic [NUM_RECTS*CW-1:0] rect_x0,
    input  logic [NUM_RECTS*CW-1:0] rect_x1,
    input  logic [NUM_RECTS*CW-1:0] rect_y0,
    input  logic [NUM_RECTS*CW-1:0] rect_y1,
    input  logic [NUM_RECTS*3-1:0]  rect_color,
    input  logic [2:0]              bg_color,
    output logic                    vga_h_sync,
    output logic                    vga_v_sync,
    output logic                    vga_r,
    output logic                    vga_g,
    output logic                    vga_b,
    output logic [CW-1:0]           counter_x,
    output logic [CW-1:0]           counter_y,
    output logic                    in_display,
    output logic                    frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0]           div_q, div_d;
    logic [CW-1:0]           cx_q, cx_d;
    logic [CW-1:0]           cy_q, cy_d;
    logic                    tick, line_end, frame_end, frame_wrap;

    logic [NUM_RECTS-1:0]    sh_en_q, sh_en_d;
    logic [NUM_RECTS*CW-1:0] sh_x0_q, sh_x0_d;
    logic [NUM_RECTS*CW-1:0] sh_x1_q, sh_x1_d;
    logic [NUM_RECTS*CW-1:0] sh_y0_q, sh_y0_d;
    logic [NUM_RECTS*CW-1:0] sh_y1_q, sh_y1_d;
    logic [NUM_RECTS*3-1:0]  sh_color_q, sh_color_d;
    logic [2:0]              sh_bg_q, sh_bg_d;

    logic [2:0]              rgb_q, rgb_d;
    logic                    hsync_q, hsync_d;
    logic                    vsync_q, vsync_d;
    logic                    disp_q, disp_d;
    logic                    frame_start_q, frame_start_d;

    logic                    active, hit_found;
    logic [2:0]              pix_color;

    always_comb begin
        tick       = (div_q == DIV_LAST);
        line_end   = (cx_q == H_LAST);
        frame_end  = line_end && (cy_q == V_LAST);
        frame_wrap = tick && frame_end;

        div_d = tick ? '0 : div_q + 1'b1;
        cx_d  = cx_q;
        cy_d  = cy_q;
        if (tick) begin
            if (line_end) begin
                cx_d = '0;
                cy_d = (cy_q == V_LAST) ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
        frame_start_d = frame_wrap;
    end

    // Shadow copy taken only on the frame wrap, so game logic can update at any time.
    always_comb begin
        sh_en_d    = sh_en_q;
        sh_x0_d    = sh_x0_q;
        sh_x1_d    = sh_x1_q;
        sh_y0_d    = sh_y0_q;
        sh_y1_d    = sh_y1_q;
        sh_color_d = sh_color_q;
        sh_bg_d    = sh_bg_q;
        if (frame_wrap) begin
            sh_en_d    = rect_en;
            sh_x0_d    = rect_x0;
            sh_x1_d    = rect_x1;
            sh_y0_d    = rect_y0;
            sh_y1_d    = rect_y1;
            sh_color_d = rect_color;
            sh_bg_d    = bg_color;
        end
    end

    always_comb begin
        active    = (cx_q < H_ACT) && (cy_q < V_ACT);
        hit_found = 1'b0;
        pix_color = sh_bg_q;
        for (int unsigned i = 0; i < NUM_RECTS; i++) begin
            if (!hit_found && sh_en_q[i] &&
                (cx_q >= sh_x0_q[i*CW +: CW]) && (cx_q <= sh_x1_q[i*CW +: CW]) &&
                (cy_q >= sh_y0_q[i*CW +: CW]) && (cy_q <= sh_y1_q[i*CW +: CW])) begin
                hit_found = 1'b1;
                pix_color = sh_color_q[i*3 +: 3];
            end
        end
`ifdef VGA_BORDER_EN
        if ((cx_q == '0) || (cx_q == CW'(H_ACTIVE - 1)) ||
            (cy_q == '0) || (cy_q == CW'(V_ACTIVE - 1))) begin
            pix_color = 3'b111;
        end
`endif

        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        disp_d  = disp_q;
        if (tick) begin
            rgb_d   = active ? pix_color : 3'b000;
            hsync_d = !((cx_q >= HS_FIRST) && (cx_q <= HS_LAST));
            vsync_d = !((cy_q >= VS_FIRST) && (cy_q <= VS_LAST));
            disp_d  = active;
        end
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            div_q         <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            sh_en_q       <= '0;
            sh_x0_q       <= '0;
            sh_x1_q       <= '0;
            sh_y0_q       <= '0;
            sh_y1_q       <= '0;
            sh_color_q    <= '0;
            sh_bg_q       <= '0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            disp_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            sh_en_q       <= sh_en_d;
            sh_x0_q       <= sh_x0_d;
            sh_x1_q       <= sh_x1_d;
            sh_y0_q       <= sh_y0_d;
            sh_y1_q       <= sh_y1_d;
            sh_color_q    <= sh_color_d;
            sh_bg_q       <= sh_bg_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            disp_q        <= disp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign counter_x   = cx_q;
    assign counter_y   = cy_q;
    assign vga_r       = rgb_q[2];
    assign vga_g       = rgb_q[1];
    assign vga_b       = rgb_q[0];
    assign vga_h_sync  = hsync_q;
    assign vga_v_sync  = vsync_q;
    assign in_display  = disp_q;
    assign frame_start = frame_start_q;

endmodule
